// File: rtl/pool3_flatten_buffer.sv
// Layer-3 pooling receiver: captures DEPTH strobed 8-channel samples into a
// local store, then replays them channel-major (index = ch*DEPTH + pos) as a
// valid/ready byte stream toward the dense-layer controller.
module pool3_flatten_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             maxflagin,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  // Channel count is pinned by the in1..in8 port list.
  localparam int unsigned CHANNELS = 8;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(CHANNELS);
  localparam logic [PW-1:0] LastPos = PW'(DEPTH - 1);
  localparam logic [CW-1:0] LastCh  = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StStream} state_e;

  state_e           r_state;
  logic [PW-1:0]    r_wr_pos;
  logic [PW-1:0]    r_rd_pos;
  logic [CW-1:0]    r_rd_ch;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_done;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [CHANNELS][DEPTH];

  logic [WIDTH-1:0] w_in [CHANNELS];
  logic             w_hs;
  logic             w_pos_wrap;
  logic             w_rd_last;
  logic [PW-1:0]    w_nxt_pos;
  logic [CW-1:0]    w_nxt_ch;
  logic             w_wr_en;

  assign w_in[0] = in1;
  assign w_in[1] = in2;
  assign w_in[2] = in3;
  assign w_in[3] = in4;
  assign w_in[4] = in5;
  assign w_in[5] = in6;
  assign w_in[6] = in7;
  assign w_in[7] = in8;

  assign w_hs       = r_out_valid && out_ready;
  assign w_pos_wrap = (r_rd_pos == LastPos);
  assign w_rd_last  = (r_rd_ch == LastCh) && w_pos_wrap;
  assign w_nxt_pos  = w_pos_wrap ? '0 : r_rd_pos + PW'(1);
  assign w_nxt_ch   = w_pos_wrap ? r_rd_ch + CW'(1) : r_rd_ch;
  assign w_wr_en    = !rst && (r_state == StCollect) && maxflagin;

  // Sample store: one column per strobe, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_mem[c][r_wr_pos] <= w_in[c];
      end
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wr_pos    <= '0;
      r_rd_pos    <= '0;
      r_rd_ch     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StCollect;
            r_wr_pos   <= '0;
            r_overflow <= 1'b0;
          end else if (maxflagin) begin
            r_overflow <= 1'b1;
          end
        end
        StCollect: begin
          if (maxflagin) begin
            r_wr_pos <= r_wr_pos + PW'(1);
            if (r_wr_pos == LastPos) begin
              r_state     <= StStream;
              r_rd_ch     <= '0;
              r_rd_pos    <= '0;
              r_out_valid <= 1'b1;
              // Element 0 was written by the first strobe, so the store holds it already.
              r_out_data  <= r_mem[0][0];
              r_out_last  <= (LastCh == '0) && (LastPos == '0);
            end
          end
        end
        StStream: begin
          if (maxflagin) begin
            r_overflow <= 1'b1;
          end
          if (w_hs) begin
            if (w_rd_last) begin
              r_state     <= StIdle;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_rd_pos   <= w_nxt_pos;
              r_rd_ch    <= w_nxt_ch;
              r_out_data <= r_mem[w_nxt_ch][w_nxt_pos];
              r_out_last <= (w_nxt_ch == LastCh) && (w_nxt_pos == LastPos);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign busy      = (r_state != StIdle);

endmodule
